// File: rtl/tx_redundant_pkg.sv
// Shared types and constants for the redundant transmit path.
// State encoding, legal copy counts and the frame-ID width.
package tx_redundant_pkg;

   localparam int ID_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      GAP
   } state_t;

   localparam logic [7:0] RED_1 = 8'd1;
   localparam logic [7:0] RED_3 = 8'd3;
   localparam logic [7:0] RED_5 = 8'd5;

   function automatic logic is_legal_red(input logic [7:0] r);
      return (r == RED_1) || (r == RED_3) || (r == RED_5);
   endfunction

endpackage

// File: rtl/tx_frame_buf.sv
// Simple dual-port byte RAM holding one payload frame.
// Ports: i_clk, write (i_we/i_waddr/i_wdata), read (i_raddr -> o_rdata, 1-cycle).
module tx_frame_buf #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/tx_redundant.sv
// Captures one payload frame, inserts an ID byte and replays it 1/3/5 times.
// Ports: clk125MHz/reset, in_en/in_data/redundancy in, ready/tx_en/tx_data/frame_id/drop out.
module tx_redundant
   import tx_redundant_pkg::*;
#(
   parameter logic [5:0] ID_LOCATION = 6'h0,
   parameter int         MAX_LEN     = 1024,
   parameter int         IFG_CYCLES  = 12
) (
   input  logic            clk125MHz,
   input  logic            reset,
   input  logic            in_en,
   input  logic [7:0]      in_data,
   input  logic [7:0]      redundancy,
   output logic            ready,
   output logic            tx_en,
   output logic [7:0]      tx_data,
   output logic [ID_W-1:0] frame_id,
   output logic            drop
);

   localparam int AW = $clog2(MAX_LEN);
   localparam int LW = AW + 1;
   localparam int GW = $clog2(IFG_CYCLES + 2);

   state_t            r_state;
   state_t            w_next;
   logic [LW-1:0]     r_len;
   logic [LW-1:0]     r_pos;
   logic              r_ovf;
   logic [7:0]        r_red;
   logic [7:0]        r_copy;
   logic [GW-1:0]     r_gap;
   logic [ID_W-1:0]   r_id_cnt;
   logic [ID_W-1:0]   r_fid;
   logic              r_in_prev;
   logic              r_drop;
   logic              r_p1_vld;
   logic              r_p1_id;
   logic              r_tx_en;
   logic [7:0]        r_tx_data;

   logic              w_rise;
   logic              w_go;
   logic              w_room;
   logic              w_more;
   logic              w_gap_done;
   logic              w_drop;
   logic              w_issue;
   logic              w_isid;
   logic [LW-1:0]     w_ipos;
   logic [LW-1:0]     w_k;
   logic              w_we;
   logic [AW-1:0]     w_waddr;
   logic [AW-1:0]     w_raddr;
   logic [7:0]        w_rdata;

   // Only a fresh rising edge starts a frame, so a burst that began while
   // busy is never picked up part-way through once IDLE is reached.
   assign w_rise     = in_en & ~r_in_prev;
   assign w_go       = is_legal_red(r_red) & ~r_ovf;
   assign w_room     = (r_len < LW'(MAX_LEN));
   assign w_more     = (r_copy < r_red);
   assign w_gap_done = (r_gap == GW'(IFG_CYCLES));
   assign w_k        = (LW'(ID_LOCATION) < r_len) ? LW'(ID_LOCATION) : r_len;

   // Output position p maps to payload p before the ID slot, p-1 after it.
   assign w_isid  = (w_ipos == w_k);
   assign w_raddr = (w_ipos < w_k) ? w_ipos[AW-1:0]
                                   : w_ipos[AW-1:0] - AW'(1);

   assign w_we    = ((r_state == IDLE) & w_rise)
                  | ((r_state == LOAD) & in_en & w_room);
   assign w_waddr = (r_state == IDLE) ? '0 : r_len[AW-1:0];

   assign w_drop  = ((r_state == LOAD) & ~in_en & ~w_go)
                  | (((r_state == SEND) | (r_state == GAP)) & w_rise);

   // Position 0 of each copy is issued in the cycle that enters SEND, which
   // gives the 2-cycle in_en-fall to tx_en latency and a 12-cycle gap.
   always_comb begin
      w_next  = r_state;
      w_issue = 1'b0;
      w_ipos  = '0;
      unique case (r_state)
         IDLE: begin
            if (w_rise) w_next = LOAD;
         end
         LOAD: begin
            if (!in_en) begin
               if (w_go) begin
                  w_next  = SEND;
                  w_issue = 1'b1;
               end else begin
                  w_next = IDLE;
               end
            end
         end
         SEND: begin
            w_issue = 1'b1;
            w_ipos  = r_pos;
            if (r_pos == r_len) w_next = GAP;
         end
         GAP: begin
            if (w_gap_done) begin
               if (w_more) begin
                  w_next  = SEND;
                  w_issue = 1'b1;
               end else begin
                  w_next = IDLE;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk125MHz or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_len     <= '0;
         r_pos     <= '0;
         r_ovf     <= 1'b0;
         r_red     <= '0;
         r_copy    <= '0;
         r_gap     <= '0;
         r_id_cnt  <= '0;
         r_fid     <= '0;
         r_in_prev <= 1'b0;
         r_drop    <= 1'b0;
         r_p1_vld  <= 1'b0;
         r_p1_id   <= 1'b0;
         r_tx_en   <= 1'b0;
         r_tx_data <= '0;
      end else begin
         r_state   <= w_next;
         r_in_prev <= in_en;
         r_drop    <= w_drop;
         r_p1_vld  <= w_issue;
         r_p1_id   <= w_isid;
         r_tx_en   <= r_p1_vld;
         r_tx_data <= !r_p1_vld ? '0 : (r_p1_id ? r_fid : w_rdata);
         if (w_issue) r_pos <= w_ipos + LW'(1);
         unique case (r_state)
            IDLE: begin
               if (w_rise) begin
                  r_len  <= LW'(1);
                  r_ovf  <= 1'b0;
                  r_red  <= redundancy;
                  r_copy <= '0;
               end
            end
            LOAD: begin
               if (in_en) begin
                  if (w_room) r_len <= r_len + LW'(1);
                  else        r_ovf <= 1'b1;
               end else if (w_go) begin
                  r_fid <= r_id_cnt;
               end
            end
            SEND: begin
               if (r_pos == r_len) begin
                  r_copy <= r_copy + 8'd1;
                  r_gap  <= '0;
               end
            end
            GAP: begin
               r_gap <= r_gap + GW'(1);
               if (w_gap_done && !w_more) begin
                  r_id_cnt <= r_id_cnt + 8'd1;
                  r_copy   <= '0;
                  r_len    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   tx_frame_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .i_clk   (clk125MHz),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (in_data),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   assign ready    = (r_state == IDLE);
   assign tx_en    = r_tx_en;
   assign tx_data  = r_tx_data;
   assign frame_id = r_fid;
   assign drop     = r_drop;

endmodule

// File: tb/tb_tx_redundant.sv
// Directed bench for tx_redundant: three instances differing only in ID_LOCATION.
// All share stimulus; a negedge monitor records bytes, run edges and drops.
module tb_tx_redundant;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_en = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic [7:0] redundancy = 8'h00;

   logic [2:0] rdy;
   logic [2:0] ten;
   logic [2:0] drp;
   logic [7:0] txd [3];
   logic [7:0] fid [3];

   int         checks = 0;
   int         fails = 0;
   int         cyc = 0;
   logic [7:0] exp_id = 8'h00;

   logic [7:0] bq [3][$];
   int         st [3][$];
   int         en [3][$];
   int         dc [3] = '{0, 0, 0};
   logic [2:0] tprev = 3'b000;

   always #4 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (ten[i]) bq[i].push_back(txd[i]);
         if (ten[i] && !tprev[i]) st[i].push_back(cyc);
         if (!ten[i] && tprev[i]) en[i].push_back(cyc - 1);
         if (drp[i]) dc[i] <= dc[i] + 1;
         tprev[i] <= ten[i];
      end
   end

   tx_redundant #(.ID_LOCATION(6'd0)) u0 (
      .clk125MHz(clk), .reset(rst_n), .in_en(in_en),
      .in_data(in_data), .redundancy(redundancy),
      .ready(rdy[0]), .tx_en(ten[0]), .tx_data(txd[0]),
      .frame_id(fid[0]), .drop(drp[0])
   );

   tx_redundant #(.ID_LOCATION(6'd2)) u2 (
      .clk125MHz(clk), .reset(rst_n), .in_en(in_en),
      .in_data(in_data), .redundancy(redundancy),
      .ready(rdy[1]), .tx_en(ten[1]), .tx_data(txd[1]),
      .frame_id(fid[1]), .drop(drp[1])
   );

   tx_redundant #(.ID_LOCATION(6'd6)) u6 (
      .clk125MHz(clk), .reset(rst_n), .in_en(in_en),
      .in_data(in_data), .redundancy(redundancy),
      .ready(rdy[2]), .tx_en(ten[2]), .tx_data(txd[2]),
      .frame_id(fid[2]), .drop(drp[2])
   );

   function automatic bq_t mk_copy(bq_t p, int k, logic [7:0] id);
      bq_t r;
      int  kk;
      kk = (k < p.size()) ? k : p.size();
      r = {};
      for (int i = 0; i < kk; i++) r.push_back(p[i]);
      r.push_back(id);
      for (int i = kk; i < p.size(); i++) r.push_back(p[i]);
      return r;
   endfunction

   function automatic int ndiff(int inst, int base, bq_t e);
      int n = 0;
      if (bq[inst].size() - base != e.size()) n++;
      for (int i = 0; i < e.size(); i++) begin
         if (base + i >= bq[inst].size()) n++;
         else if (bq[inst][base + i] !== e[i]) n++;
      end
      return n;
   endfunction

   task automatic drive_frame(input bq_t p, input logic [7:0] red,
                              output int tf);
      @(negedge clk);
      redundancy = red;
      for (int i = 0; i < p.size(); i++) begin
         in_en   = 1'b1;
         in_data = p[i];
         @(negedge clk);
         redundancy = 8'hFF;
      end
      in_en   = 1'b0;
      in_data = 8'h00;
      tf      = cyc;
   endtask

   task automatic wait_ready(output bit ok);
      int n = 0;
      @(negedge clk);
      while (rdy[0] !== 1'b1 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      ok = (rdy[0] === 1'b1);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (rdy[0] !== 1'b1) begin
         fails++; $display("FAIL rst_ready got=%b want=1", rdy[0]);
      end
      checks++;
      if (ten[0] !== 1'b0) begin
         fails++; $display("FAIL rst_tx_en got=%b want=0", ten[0]);
      end
      checks++;
      if (txd[0] !== 8'h00) begin
         fails++; $display("FAIL rst_tx_data got=%h want=00", txd[0]);
      end
      checks++;
      if (fid[0] !== 8'h00) begin
         fails++; $display("FAIL rst_frame_id got=%h want=00", fid[0]);
      end
      checks++;
      if (drp[0] !== 1'b0) begin
         fails++; $display("FAIL rst_drop got=%b want=0", drp[0]);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      exp_id = 8'h00;
   endtask

   task automatic test_basic();
      bq_t        p, e;
      int         tf, b, s, en0, n0, d, g;
      bit         ok;
      logic [7:0] id;
      p   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      id  = exp_id;
      b   = bq[0].size();
      s   = st[0].size();
      en0 = en[0].size();
      n0  = dc[0];
      drive_frame(p, 8'd3, tf);
      wait_ready(ok);
      checks++;
      if (!ok) begin
         fails++; $display("FAIL basic_ready got=0 want=1");
      end
      e = {};
      for (int c = 0; c < 3; c++) e = {e, mk_copy(p, 0, id)};
      d = ndiff(0, b, e);
      checks++;
      if (d != 0) begin
         fails++; $display("FAIL basic_bytes diffs=%0d want=0", d);
      end
      checks++;
      if (st[0].size() - s != 3) begin
         fails++;
         $display("FAIL basic_copies got=%0d want=3", st[0].size() - s);
      end
      g = (st[0].size() > s) ? st[0][s] - tf : -1;
      checks++;
      if (g != 2) begin
         fails++; $display("FAIL basic_latency got=%0d want=2", g);
      end
      for (int c = 0; c < 3; c++) begin
         g = (st[0].size() > s + c && en[0].size() > en0 + c)
           ? en[0][en0 + c] - st[0][s + c] + 1 : -1;
         checks++;
         if (g != 5) begin
            fails++; $display("FAIL basic_runlen%0d got=%0d want=5", c, g);
         end
      end
      for (int c = 0; c < 2; c++) begin
         g = (st[0].size() > s + c + 1 && en[0].size() > en0 + c)
           ? st[0][s + c + 1] - en[0][en0 + c] - 1 : -1;
         checks++;
         if (g != 12) begin
            fails++; $display("FAIL basic_gap%0d got=%0d want=12", c, g);
         end
      end
      checks++;
      if (fid[0] !== id) begin
         fails++; $display("FAIL basic_frame_id got=%h want=%h", fid[0], id);
      end
      checks++;
      if (dc[0] - n0 != 0) begin
         fails++; $display("FAIL basic_drop got=%0d want=0", dc[0] - n0);
      end
      exp_id = id + 8'd1;
   endtask

   task automatic test_id_location();
      bq_t        p, e;
      int         tf, d, s;
      int         b [3];
      bit         ok;
      logic [7:0] id;
      int         k [3] = '{0, 2, 6};
      p  = '{8'h11, 8'h22, 8'h33};
      id = exp_id;
      s  = st[0].size();
      for (int i = 0; i < 3; i++) b[i] = bq[i].size();
      drive_frame(p, 8'd5, tf);
      wait_ready(ok);
      checks++;
      if (!ok) begin
         fails++; $display("FAIL idloc_ready got=0 want=1");
      end
      for (int i = 0; i < 3; i++) begin
         e = {};
         for (int c = 0; c < 5; c++) e = {e, mk_copy(p, k[i], id)};
         d = ndiff(i, b[i], e);
         checks++;
         if (d != 0) begin
            fails++; $display("FAIL idloc_bytes_k%0d diffs=%0d want=0", k[i], d);
         end
         checks++;
         if (fid[i] !== id) begin
            fails++;
            $display("FAIL idloc_fid_k%0d got=%h want=%h", k[i], fid[i], id);
         end
      end
      checks++;
      if (st[0].size() - s != 5) begin
         fails++;
         $display("FAIL idloc_copies got=%0d want=5", st[0].size() - s);
      end
      exp_id = id + 8'd1;
   endtask

   task automatic test_illegal_red();
      bq_t        p;
      int         tf, b, n0;
      bit         ok;
      logic [7:0] last;
      logic [7:0] reds [2] = '{8'd2, 8'd0};
      p    = '{8'h55, 8'h66};
      last = exp_id - 8'd1;
      for (int r = 0; r < 2; r++) begin
         b  = bq[0].size();
         n0 = dc[0];
         drive_frame(p, reds[r], tf);
         wait_ready(ok);
         checks++;
         if (bq[0].size() - b != 0) begin
            fails++;
            $display("FAIL illegal%0d_bytes got=%0d want=0", reds[r],
                     bq[0].size() - b);
         end
         checks++;
         if (dc[0] - n0 != 1) begin
            fails++;
            $display("FAIL illegal%0d_drop got=%0d want=1", reds[r], dc[0] - n0);
         end
         checks++;
         if (fid[0] !== last || !ok) begin
            fails++;
            $display("FAIL illegal%0d_fid got=%h want=%h rdy=%b", reds[r],
                     fid[0], last, ok);
         end
      end
   endtask

   task automatic test_overflow();
      bq_t        p, e;
      int         tf, b, n0, d;
      bit         ok;
      logic [7:0] id;
      p = {};
      for (int i = 0; i < 1025; i++) p.push_back(8'(i));
      b  = bq[0].size();
      n0 = dc[0];
      drive_frame(p, 8'd1, tf);
      wait_ready(ok);
      checks++;
      if (bq[0].size() - b != 0 || !ok) begin
         fails++;
         $display("FAIL ovf_bytes got=%0d want=0", bq[0].size() - b);
      end
      checks++;
      if (dc[0] - n0 != 1) begin
         fails++; $display("FAIL ovf_drop got=%0d want=1", dc[0] - n0);
      end
      id = exp_id;
      p  = '{8'h01, 8'h02};
      b  = bq[0].size();
      drive_frame(p, 8'd1, tf);
      wait_ready(ok);
      d = ndiff(0, b, mk_copy(p, 0, id));
      checks++;
      if (d != 0 || !ok) begin
         fails++; $display("FAIL ovf_next_bytes diffs=%0d want=0", d);
      end
      checks++;
      if (fid[0] !== id) begin
         fails++; $display("FAIL ovf_next_fid got=%h want=%h", fid[0], id);
      end
      id = id + 8'd1;
      p  = {};
      for (int i = 0; i < 1024; i++) p.push_back(8'(i * 7));
      b  = bq[0].size();
      n0 = dc[0];
      drive_frame(p, 8'd1, tf);
      wait_ready(ok);
      e = mk_copy(p, 0, id);
      d = ndiff(0, b, e);
      checks++;
      if (d != 0 || !ok) begin
         fails++; $display("FAIL maxlen_bytes diffs=%0d want=0", d);
      end
      checks++;
      if (dc[0] - n0 != 0) begin
         fails++; $display("FAIL maxlen_drop got=%0d want=0", dc[0] - n0);
      end
      exp_id = id + 8'd1;
   endtask

   task automatic test_busy_burst();
      bq_t        p, e;
      int         tf, b, s, n0, d, n;
      bit         ok;
      logic [7:0] id;
      p  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
      id = exp_id;
      b  = bq[0].size();
      s  = st[0].size();
      n0 = dc[0];
      drive_frame(p, 8'd3, tf);
      n = 0;
      while (st[0].size() < s + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (st[0].size() < s + 2) begin
         fails++;
         $display("FAIL busy_copy2 got=%0d want=2", st[0].size() - s);
      end
      for (int j = 0; j < 3; j++) begin
         in_en   = 1'b1;
         in_data = 8'hFF;
         @(negedge clk);
      end
      checks++;
      if (rdy[0] !== 1'b0) begin
         fails++; $display("FAIL busy_ready got=%b want=0", rdy[0]);
      end
      in_en   = 1'b0;
      in_data = 8'h00;
      wait_ready(ok);
      repeat (30) @(negedge clk);
      checks++;
      if (!ok || rdy[0] !== 1'b1) begin
         fails++; $display("FAIL busy_ready_end got=%b want=1", rdy[0]);
      end
      e = {};
      for (int c = 0; c < 3; c++) e = {e, mk_copy(p, 0, id)};
      d = ndiff(0, b, e);
      checks++;
      if (d != 0) begin
         fails++; $display("FAIL busy_bytes diffs=%0d want=0", d);
      end
      checks++;
      if (dc[0] - n0 != 1) begin
         fails++; $display("FAIL busy_drop got=%0d want=1", dc[0] - n0);
      end
      exp_id = id + 8'd1;
   endtask

   task automatic test_id_wrap();
      bq_t        p, e;
      int         tf, b, d;
      bit         ok;
      logic [7:0] id, dv;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      for (int f = 0; f < 257; f++) begin
         id = 8'(f);
         dv = 8'(f) ^ 8'h5A;
         p  = {dv};
         b  = bq[0].size();
         drive_frame(p, 8'd1, tf);
         wait_ready(ok);
         e = {id, dv};
         d = ndiff(0, b, e);
         checks++;
         if (d != 0 || !ok) begin
            fails++; $display("FAIL wrap_bytes f=%0d diffs=%0d want=0", f, d);
         end
         checks++;
         if (fid[0] !== id) begin
            fails++;
            $display("FAIL wrap_fid f=%0d got=%h want=%h", f, fid[0], id);
         end
      end
   endtask

   task automatic test_reset_mid();
      bq_t p;
      int  tf, b, n;
      p = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
      drive_frame(p, 8'd3, tf);
      n = 0;
      while (ten[0] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (ten[0] !== 1'b1) begin
         fails++; $display("FAIL midrst_start got=%b want=1", ten[0]);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ten[0] !== 1'b0) begin
         fails++; $display("FAIL midrst_tx_en got=%b want=0", ten[0]);
      end
      checks++;
      if (fid[0] !== 8'h00) begin
         fails++; $display("FAIL midrst_fid got=%h want=00", fid[0]);
      end
      checks++;
      if (rdy[0] !== 1'b1) begin
         fails++; $display("FAIL midrst_ready got=%b want=1", rdy[0]);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      b = bq[0].size();
      repeat (40) @(negedge clk);
      checks++;
      if (bq[0].size() - b != 0) begin
         fails++;
         $display("FAIL midrst_resume got=%0d want=0", bq[0].size() - b);
      end
      checks++;
      if (rdy[0] !== 1'b1) begin
         fails++; $display("FAIL midrst_ready_after got=%b want=1", rdy[0]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_id_location();
      test_illegal_red();
      test_overflow();
      test_busy_burst();
      test_id_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
